// File: rtl/store_queue_drain_ctrl_pkg.sv
// Shared types for the store queue drain path: widths of the SQ index/count,
// cache write bus types, the drain FSM state and the block-to-byte address helper.
package store_queue_drain_ctrl_pkg;

   localparam int CONF_STORE_QUEUE_ENTRY_NUM = 16;
   localparam int CONF_COMMIT_WIDTH          = 2;
   localparam int CONF_REFILL_BACKOFF_CYCLES = 2;

   localparam int PHY_ADDR_WIDTH       = 32;
   localparam int LSQ_BLOCK_BYTE_NUM   = 4;
   localparam int LSQ_BLOCK_OFFSET_BIT = $clog2(LSQ_BLOCK_BYTE_NUM);
   localparam int LSQ_BLOCK_WIDTH      = 8 * LSQ_BLOCK_BYTE_NUM;
   localparam int LSQ_BLOCK_ADDR_WIDTH = PHY_ADDR_WIDTH - LSQ_BLOCK_OFFSET_BIT;

   localparam int STORE_QUEUE_INDEX_WIDTH =
      (CONF_STORE_QUEUE_ENTRY_NUM > 1) ? $clog2(CONF_STORE_QUEUE_ENTRY_NUM) : 1;
   localparam int STORE_QUEUE_COUNT_WIDTH   = $clog2(CONF_STORE_QUEUE_ENTRY_NUM + 1);
   localparam int STORE_COMMIT_NUM_WIDTH    = $clog2(CONF_COMMIT_WIDTH + 1);
   localparam int STORE_DRAIN_BACKOFF_WIDTH =
      ($clog2(CONF_REFILL_BACKOFF_CYCLES + 1) > 1) ? $clog2(CONF_REFILL_BACKOFF_CYCLES + 1) : 1;

   typedef logic [PHY_ADDR_WIDTH-1:0]            PhyAddrPath;
   typedef logic [LSQ_BLOCK_ADDR_WIDTH-1:0]      LSQ_BlockAddrPath;
   typedef logic [LSQ_BLOCK_WIDTH-1:0]           LSQ_BlockDataPath;
   typedef logic [LSQ_BLOCK_BYTE_NUM-1:0]        LSQ_WordByteEnablePath;
   typedef logic [STORE_QUEUE_INDEX_WIDTH-1:0]   StoreQueueIndexPath;
   typedef logic [STORE_QUEUE_COUNT_WIDTH-1:0]   StoreQueueCountPath;
   typedef logic [STORE_COMMIT_NUM_WIDTH-1:0]    StoreCommitNumPath;
   typedef logic [STORE_DRAIN_BACKOFF_WIDTH-1:0] StoreDrainBackoffPath;

   typedef enum logic [1:0] {
      DRAIN_IDLE        = 2'd0,
      DRAIN_ISSUE       = 2'd1,
      DRAIN_WAIT_REFILL = 2'd2,
      DRAIN_BACKOFF     = 2'd3
   } StoreDrainState;

   // A block address names an aligned block; the byte address appends a zero offset.
   function automatic PhyAddrPath LSQ_ToFullAddrFromBlockAddr(input LSQ_BlockAddrPath blockAddr);
      return {blockAddr, {LSQ_BLOCK_OFFSET_BIT{1'b0}}};
   endfunction

endpackage

// File: rtl/store_queue_drain_ctrl_if.sv
// D-cache store port bundle: the drain controller is the master presenting
// writes, the cache is the slave answering with ack/nack and refill completion.
interface store_queue_drain_ctrl_if;
   import store_queue_drain_ctrl_pkg::*;

   logic                  dcWriteReq;
   PhyAddrPath            dcWriteAddr;
   LSQ_BlockDataPath      dcWriteData;
   LSQ_WordByteEnablePath dcWriteByteWE;
   logic                  dcWriteAck;
   logic                  dcWriteNack;
   logic                  dcRefillDone;

   modport master (
      output dcWriteReq, dcWriteAddr, dcWriteData, dcWriteByteWE,
      input  dcWriteAck, dcWriteNack, dcRefillDone
   );

   modport slave (
      input  dcWriteReq, dcWriteAddr, dcWriteData, dcWriteByteWE,
      output dcWriteAck, dcWriteNack, dcRefillDone
   );

endinterface

// File: rtl/store_queue_drain_ctrl.sv
// Drains committed stores from the store queue head into the D-cache, one at a
// time and oldest first, retrying after a miss once the refill has landed.
// Port types are sized by the package CONF_* values; keep the parameters equal.
module store_queue_drain_ctrl
   import store_queue_drain_ctrl_pkg::*;
#(
   parameter int STORE_QUEUE_ENTRY_NUM = CONF_STORE_QUEUE_ENTRY_NUM,
   parameter int COMMIT_WIDTH          = CONF_COMMIT_WIDTH,
   parameter int REFILL_BACKOFF_CYCLES = CONF_REFILL_BACKOFF_CYCLES
) (
   input  logic                     clk,
   input  logic                     rst,
   input  StoreCommitNumPath        commitStoreNum,
   output StoreQueueIndexPath       headPtr,
   input  LSQ_BlockAddrPath         headAddr,
   input  LSQ_BlockDataPath         headData,
   input  LSQ_WordByteEnablePath    headByteWE,
   store_queue_drain_ctrl_if.master dc,
   output logic                     releaseEntry,
   output StoreQueueCountPath       pendingCount,
   output logic                     drainIdle
);

   localparam int SUM_WIDTH = STORE_QUEUE_COUNT_WIDTH + 1;

   StoreDrainState       state;
   StoreDrainState       next_state;
   StoreDrainBackoffPath backoff_count;
   StoreDrainBackoffPath next_backoff;
   logic                 release_now;
   logic                 load_request;
   logic [SUM_WIDTH-1:0] pending_sum;

   // The head entry is freed on the cycle the cache accepts it while issuing.
   assign release_now  = (state == DRAIN_ISSUE) && dc.dcWriteAck;
   assign load_request = (state == DRAIN_IDLE) && (pendingCount != '0);
   assign pending_sum  = {1'b0, pendingCount} + SUM_WIDTH'(commitStoreNum)
                         - SUM_WIDTH'(release_now);

   // Fences may proceed only when nothing is queued and no write is in flight.
   assign drainIdle = (state == DRAIN_IDLE) && (pendingCount == '0);

   // Next-state logic: ack beats nack, refill only matters while waiting for it.
   always_comb begin
      next_state   = state;
      next_backoff = backoff_count;
      unique case (state)
         DRAIN_IDLE: begin
            if (pendingCount != '0) next_state = DRAIN_ISSUE;
         end
         DRAIN_ISSUE: begin
            if (dc.dcWriteAck)       next_state = DRAIN_IDLE;
            else if (dc.dcWriteNack) next_state = DRAIN_WAIT_REFILL;
         end
         DRAIN_WAIT_REFILL: begin
            if (dc.dcRefillDone) begin
               if (REFILL_BACKOFF_CYCLES == 0) begin
                  next_state = DRAIN_ISSUE;
               end else begin
                  next_state   = DRAIN_BACKOFF;
                  next_backoff = StoreDrainBackoffPath'(REFILL_BACKOFF_CYCLES);
               end
            end
         end
         DRAIN_BACKOFF: begin
            if (backoff_count <= StoreDrainBackoffPath'(1)) begin
               next_state   = DRAIN_ISSUE;
               next_backoff = '0;
            end else begin
               next_backoff = backoff_count - StoreDrainBackoffPath'(1);
            end
         end
         default: next_state = DRAIN_IDLE;
      endcase
   end

   // State register and backoff counter; reset drops any in-flight request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= DRAIN_IDLE;
         backoff_count <= '0;
      end else begin
         state         <= next_state;
         backoff_count <= next_backoff;
      end
   end

   // Request register: the latched write is re-presented unchanged on every retry.
   always_ff @(posedge clk) begin
      if (rst) begin
         dc.dcWriteReq    <= 1'b0;
         dc.dcWriteAddr   <= '0;
         dc.dcWriteData   <= '0;
         dc.dcWriteByteWE <= '0;
      end else begin
         dc.dcWriteReq <= (next_state == DRAIN_ISSUE);
         if (load_request) begin
            dc.dcWriteAddr   <= LSQ_ToFullAddrFromBlockAddr(headAddr);
            dc.dcWriteData   <= headData;
            dc.dcWriteByteWE <= headByteWE;
         end
      end
   end

   // Head pointer, release pulse and pending count: commits and a release in
   // the same cycle both take effect.
   always_ff @(posedge clk) begin
      if (rst) begin
         headPtr      <= '0;
         releaseEntry <= 1'b0;
         pendingCount <= '0;
      end else begin
         releaseEntry <= release_now;
         pendingCount <= pending_sum[STORE_QUEUE_COUNT_WIDTH-1:0];
         if (release_now) begin
            if (headPtr == StoreQueueIndexPath'(STORE_QUEUE_ENTRY_NUM - 1))
               headPtr <= '0;
            else
               headPtr <= headPtr + StoreQueueIndexPath'(1);
         end
      end
   end

   assert property (@(posedge clk) disable iff (rst)
      pending_sum <= SUM_WIDTH'(STORE_QUEUE_ENTRY_NUM));

   assert property (@(posedge clk) disable iff (rst)
      (state == DRAIN_ISSUE) |-> !(dc.dcWriteAck && dc.dcWriteNack));

   assert property (@(posedge clk) disable iff (rst)
      commitStoreNum <= StoreCommitNumPath'(COMMIT_WIDTH));

endmodule

// File: tb/tb_store_queue_drain_ctrl.sv
// Self-checking bench for store_queue_drain_ctrl: directed scenarios followed by
// randomized traffic, all checked against a transaction-level reference model.
module tb_store_queue_drain_ctrl;
   import store_queue_drain_ctrl_pkg::*;

   localparam int ENTRIES = CONF_STORE_QUEUE_ENTRY_NUM;
   localparam int BACKOFF = CONF_REFILL_BACKOFF_CYCLES;

   typedef struct packed {
      LSQ_BlockAddrPath      addr;
      LSQ_BlockDataPath      data;
      LSQ_WordByteEnablePath byteWE;
   } StoreEntry;

   logic                  clk = 1'b0;
   logic                  rst;
   StoreCommitNumPath     commitStoreNum;
   StoreQueueIndexPath    headPtr;
   LSQ_BlockAddrPath      headAddr;
   LSQ_BlockDataPath      headData;
   LSQ_WordByteEnablePath headByteWE;
   logic                  releaseEntry;
   StoreQueueCountPath    pendingCount;
   logic                  drainIdle;

   store_queue_drain_ctrl_if dc ();

   LSQ_BlockAddrPath      sqAddr   [ENTRIES];
   LSQ_BlockDataPath      sqData   [ENTRIES];
   LSQ_WordByteEnablePath sqByteWE [ENTRIES];

   assign headAddr   = sqAddr[headPtr];
   assign headData   = sqData[headPtr];
   assign headByteWE = sqByteWE[headPtr];

   store_queue_drain_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .commitStoreNum (commitStoreNum),
      .headPtr        (headPtr),
      .headAddr       (headAddr),
      .headData       (headData),
      .headByteWE     (headByteWE),
      .dc             (dc),
      .releaseEntry   (releaseEntry),
      .pendingCount   (pendingCount),
      .drainIdle      (drainIdle)
   );

   always #5 clk = ~clk;

   int        checks = 0;
   int        failures = 0;
   StoreEntry sb[$];
   int        expPending;
   int        expHead;
   bit        expRelease;
   bit        expReq;
   bit        modelIdle;
   bit        modelWaiting;
   int        reissueAt;
   int        cycleNo = 0;
   int        tail;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cycleNo);
      end
   endtask

   // One cycle: check what the DUT shows now, drive this cycle's inputs, then
   // advance the reference model to what must be visible next cycle.
   task automatic applyStimulus(input int commitN, input bit ack, input bit nack, input bit refill,
                                input LSQ_BlockAddrPath addrBase);
      int        n;
      bit        accepted;
      bit        missed;
      bit        nextReq;
      StoreEntry e;

      checkOutput("pendingCount", 64'(pendingCount), 64'(expPending));
      checkOutput("headPtr", 64'(headPtr), 64'(expHead));
      checkOutput("releaseEntry", 64'(releaseEntry), 64'(expRelease));
      checkOutput("drainIdle", 64'(drainIdle), 64'(expPending == 0));
      checkOutput("dcWriteReq", 64'(dc.dcWriteReq), 64'(expReq));
      if (expReq && sb.size() > 0) begin
         checkOutput("dcWriteAddr", 64'(dc.dcWriteAddr), 64'(sb[0].addr) << 2);
         checkOutput("dcWriteData", 64'(dc.dcWriteData), 64'(sb[0].data));
         checkOutput("dcWriteByteWE", 64'(dc.dcWriteByteWE), 64'(sb[0].byteWE));
      end

      n = commitN;
      if (expPending + n > ENTRIES) n = ENTRIES - expPending;
      for (int i = 0; i < n; i++) begin
         e.addr   = addrBase + LSQ_BlockAddrPath'(i);
         e.data   = LSQ_BlockDataPath'($urandom);
         e.byteWE = LSQ_WordByteEnablePath'($urandom_range(1, 15));
         sqAddr[tail]   = e.addr;
         sqData[tail]   = e.data;
         sqByteWE[tail] = e.byteWE;
         sb.push_back(e);
         tail = (tail + 1) % ENTRIES;
      end
      commitStoreNum   = StoreCommitNumPath'(n);
      dc.dcWriteAck    = ack;
      dc.dcWriteNack   = nack;
      dc.dcRefillDone  = refill;

      accepted = expReq && ack;
      missed   = expReq && !ack && nack;
      nextReq  = 1'b0;
      if (expReq) begin
         if (accepted)    modelIdle = 1'b1;
         else if (missed) modelWaiting = 1'b1;
         else             nextReq = 1'b1;
      end else if (modelIdle) begin
         if (expPending > 0) begin
            nextReq   = 1'b1;
            modelIdle = 1'b0;
         end
      end else if (modelWaiting) begin
         if (refill) begin
            modelWaiting = 1'b0;
            reissueAt    = cycleNo + 1 + BACKOFF;
            nextReq      = (cycleNo + 1 == reissueAt);
         end
      end else begin
         nextReq = (cycleNo + 1 == reissueAt);
      end

      if (accepted) begin
         sb.delete(0);
         expHead = (expHead + 1) % ENTRIES;
      end
      expPending = expPending + n - (accepted ? 1 : 0);
      expRelease = accepted;
      expReq     = nextReq;
      cycleNo++;
      @(negedge clk);
   endtask

   // Holds reset across the given edges, checks reset values, restarts the model.
   task automatic doReset(input int cycles);
      rst             = 1'b1;
      commitStoreNum  = '0;
      dc.dcWriteAck   = 1'b0;
      dc.dcWriteNack  = 1'b0;
      dc.dcRefillDone = 1'b0;
      repeat (cycles) @(negedge clk);
      checkOutput("rstReq", 64'(dc.dcWriteReq), 64'd0);
      checkOutput("rstAddr", 64'(dc.dcWriteAddr), 64'd0);
      checkOutput("rstData", 64'(dc.dcWriteData), 64'd0);
      checkOutput("rstByteWE", 64'(dc.dcWriteByteWE), 64'd0);
      checkOutput("rstRelease", 64'(releaseEntry), 64'd0);
      checkOutput("rstPending", 64'(pendingCount), 64'd0);
      checkOutput("rstHeadPtr", 64'(headPtr), 64'd0);
      checkOutput("rstDrainIdle", 64'(drainIdle), 64'd1);
      rst = 1'b0;
      sb.delete();
      expPending   = 0;
      expHead      = 0;
      expRelease   = 1'b0;
      expReq       = 1'b0;
      modelIdle    = 1'b1;
      modelWaiting = 1'b0;
      reissueAt    = -1;
      tail         = 0;
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int rc;
      bit ra;
      bit rn;
      bit rr;

      for (int i = 0; i < ENTRIES; i++) begin
         sqAddr[i]   = '0;
         sqData[i]   = '0;
         sqByteWE[i] = '0;
      end
      @(negedge clk);
      doReset(2);

      // Single store committed at t with block address 0x40.
      applyStimulus(0, 0, 0, 0, '0);
      applyStimulus(1, 0, 0, 0, LSQ_BlockAddrPath'(30'h40));
      applyStimulus(0, 0, 0, 0, '0);
      checkOutput("singleReq", 64'(dc.dcWriteReq), 64'd1);
      checkOutput("singleAddr", 64'(dc.dcWriteAddr), 64'h100);
      applyStimulus(0, 1, 0, 0, '0);
      checkOutput("singleRelease", 64'(releaseEntry), 64'd1);
      applyStimulus(0, 0, 0, 0, '0);
      applyStimulus(0, 0, 0, 0, '0);

      // Miss: nack, stray ack/refill ignored, head slot scribbled, then reissue.
      applyStimulus(1, 0, 0, 0, LSQ_BlockAddrPath'($urandom));
      applyStimulus(0, 0, 0, 0, '0);
      applyStimulus(0, 0, 1, 0, '0);
      for (int k = 0; k < 10; k++) begin
         sqAddr[expHead] = ~sqAddr[expHead];
         sqData[expHead] = ~sqData[expHead];
         applyStimulus(0, k[0], 0, 0, '0);
      end
      applyStimulus(0, 0, 0, 1, '0);
      for (int k = 0; k < BACKOFF; k++) applyStimulus(0, 1, 0, 1, '0);
      checkOutput("reissueReq", 64'(dc.dcWriteReq), 64'd1);
      applyStimulus(0, 1, 0, 0, '0);
      applyStimulus(0, 0, 0, 0, '0);

      // Burst of 2+2+2 commits with ack always high.
      for (int k = 0; k < 3; k++) applyStimulus(2, 1, 0, 0, LSQ_BlockAddrPath'($urandom));
      for (int k = 0; k < 14; k++) applyStimulus(0, 1, 0, 0, '0);
      checkOutput("burstHeadPtr", 64'(headPtr), 64'd8);

      // Commit of two stores in the cycle a single pending store is acked.
      applyStimulus(1, 0, 0, 0, LSQ_BlockAddrPath'($urandom));
      applyStimulus(0, 0, 0, 0, '0);
      applyStimulus(2, 1, 0, 0, LSQ_BlockAddrPath'($urandom));
      checkOutput("simulNetCount", 64'(pendingCount), 64'd2);
      for (int k = 0; k < 6; k++) applyStimulus(0, 1, 0, 0, '0);

      // Wrap: keep draining so the head passes ENTRIES-1 back to 0.
      for (int k = 0; k < 24; k++) applyStimulus(k < 10 ? 1 : 0, 1, 0, 0, LSQ_BlockAddrPath'($urandom));
      checkOutput("wrapHeadPtr", 64'(headPtr), 64'((8 + 3 + 10) % ENTRIES));

      // Reset while waiting for a refill; the late refill must be ignored.
      applyStimulus(1, 0, 0, 0, LSQ_BlockAddrPath'($urandom));
      applyStimulus(0, 0, 0, 0, '0);
      applyStimulus(0, 0, 1, 0, '0);
      applyStimulus(0, 0, 0, 0, '0);
      doReset(1);
      for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 1, '0);

      // Randomized traffic.
      for (int k = 0; k < 3000; k++) begin
         rc = ($urandom_range(0, 9) < 4) ? int'($urandom_range(0, 2)) : 0;
         ra = ($urandom_range(0, 1) == 1);
         rn = !ra && ($urandom_range(0, 3) == 0);
         rr = ($urandom_range(0, 3) == 0);
         applyStimulus(rc, ra, rn, rr, LSQ_BlockAddrPath'($urandom));
      end
      for (int k = 0; k < 80; k++) applyStimulus(0, 1, 0, 1, '0);
      checkOutput("finalDrained", 64'(pendingCount), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
